// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HI,
    LO,
    WRITE,
    CS_HI,
    CS_LO,
    DONE,
    ERROR
  } loader_state_t;

  localparam int unsigned LOADER_WORD_W    = 16;
  localparam int unsigned LOADER_BYTE_W    = 8;
  localparam int unsigned LOADER_ADDR_STEP = 2;

endpackage

// File: rtl/imem_loader.sv
// Streams big-endian 16-bit words into instruction memory, verifies a trailing
// checksum and only then releases the CPU hold.
module imem_loader
  import loader_pkg::*;
#(
  parameter bit HOLD_AT_RESET = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [LOADER_WORD_W-1:0] base_addr,
  input  logic [LOADER_WORD_W-1:0] word_count,
  input  logic                     in_valid,
  input  logic [LOADER_BYTE_W-1:0] in_data,
  output logic                     in_ready,
  output logic                     im_wr,
  output logic                     im_en,
  output logic [LOADER_WORD_W-1:0] im_addr,
  output logic [LOADER_WORD_W-1:0] im_data,
  output logic                     cpu_hold,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  localparam logic [LOADER_WORD_W-1:0] ADDR_STEP = LOADER_WORD_W'(LOADER_ADDR_STEP);

  loader_state_t            state;
  logic [LOADER_WORD_W-1:0] addr;
  logic [LOADER_WORD_W-1:0] remaining;
  logic [LOADER_WORD_W-1:0] sum;
  logic [LOADER_BYTE_W-1:0] hi_byte;
  logic                     accept;

  assign accept = in_valid && in_ready;

  // im_data doubles as the assembled-word register consumed by the WRITE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      sum       <= '0;
      hi_byte   <= '0;
      in_ready  <= 1'b0;
      im_wr     <= 1'b0;
      im_en     <= 1'b0;
      im_addr   <= '0;
      im_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      cpu_hold  <= HOLD_AT_RESET;
    end else begin
      im_wr <= 1'b0;
      im_en <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            addr      <= base_addr & 16'hFFFE;
            remaining <= word_count;
            sum       <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
            busy      <= 1'b1;
            cpu_hold  <= 1'b1;
            in_ready  <= 1'b1;
            state     <= (word_count != '0) ? HI : CS_HI;
          end
        end
        HI: begin
          if (accept) begin
            hi_byte <= in_data;
            state   <= LO;
          end
        end
        LO: begin
          if (accept) begin
            im_data  <= {hi_byte, in_data};
            im_addr  <= addr;
            im_wr    <= 1'b1;
            im_en    <= 1'b1;
            in_ready <= 1'b0;
            state    <= WRITE;
          end
        end
        WRITE: begin
          sum       <= sum + im_data;
          addr      <= addr + ADDR_STEP;
          remaining <= remaining - 16'd1;
          in_ready  <= 1'b1;
          state     <= (remaining != 16'd1) ? HI : CS_HI;
        end
        CS_HI: begin
          if (accept) begin
            hi_byte <= in_data;
            state   <= CS_LO;
          end
        end
        CS_LO: begin
          if (accept) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            if ({hi_byte, in_data} == sum) begin
              done     <= 1'b1;
              cpu_hold <= 1'b0;
              state    <= DONE;
            end else begin
              error <= 1'b1;
              state <= ERROR;
            end
          end
        end
        default: begin
          in_ready <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: loads, checksum pass/fail, backpressure,
// address wrap, mid-session reset and ignored start.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] word_count;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        im_wr;
  logic        im_en;
  logic [15:0] im_addr;
  logic [15:0] im_data;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  int n_total = 0;
  int n_bad   = 0;

  logic [15:0] wr_addr [64];
  logic [15:0] wr_data [64];
  int          wr_n = 0;
  int          wr_ready_bad = 0;
  int          wr_en_bad = 0;

  imem_loader #(.HOLD_AT_RESET(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .im_wr      (im_wr),
    .im_en      (im_en),
    .im_addr    (im_addr),
    .im_data    (im_data),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  // Write-port monitor: one entry per cycle with im_wr high.
  always @(posedge clk) begin
    if (im_en !== im_wr) wr_en_bad++;
    if (im_wr) begin
      if (wr_n < 64) begin
        wr_addr[wr_n] = im_addr;
        wr_data[wr_n] = im_data;
      end
      wr_n++;
      if (in_ready) wr_ready_bad++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    for (int g = 0; g < gap; g++) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_start(input logic [15:0] base, input logic [15:0] cnt, input bit with_byte);
    @(negedge clk);
    start      = 1'b1;
    base_addr  = base;
    word_count = cnt;
    if (with_byte) begin
      in_valid = 1'b1;
      in_data  = 8'hFF;
    end
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  int w0;

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
    in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_im_wr", im_wr, 0);
    chk("rst_im_addr", im_addr, 0);
    chk("rst_im_data", im_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_cpu_hold", cpu_hold, 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 0);

    // Normal load
    w0 = wr_n;
    do_start(16'h0000, 16'd2, 1'b0);
    chk("n_busy", busy, 1);
    chk("n_hold", cpu_hold, 1);
    chk("n_ready", in_ready, 1);
    send_byte(8'h12, 0); send_byte(8'h34, 0);
    send_byte(8'hAB, 0); send_byte(8'hCD, 0);
    send_byte(8'hBE, 0); send_byte(8'h01, 0);
    chk("n_wr_count", wr_n - w0, 2);
    chk("n_a0", wr_addr[w0], 16'h0000);
    chk("n_d0", wr_data[w0], 16'h1234);
    chk("n_a1", wr_addr[w0+1], 16'h0002);
    chk("n_d1", wr_data[w0+1], 16'hABCD);
    chk("n_done", done, 1);
    chk("n_error", error, 0);
    chk("n_hold_rel", cpu_hold, 0);
    chk("n_busy_end", busy, 0);
    chk("n_ready_end", in_ready, 0);
    chk("n_addr_hold", im_addr, 16'h0002);
    chk("n_data_hold", im_data, 16'hABCD);

    // Zero count, start coincides with a byte that must not be taken
    w0 = wr_n;
    do_start(16'h0040, 16'd0, 1'b1);
    chk("z_done_clr", done, 0);
    chk("z_hold", cpu_hold, 1);
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    chk("z_wr_count", wr_n - w0, 0);
    chk("z_done", done, 1);
    chk("z_hold_rel", cpu_hold, 0);
    do_start(16'h0040, 16'd0, 1'b0);
    send_byte(8'hFF, 0); send_byte(8'hFF, 0);
    chk("z_err", error, 1);
    chk("z_err_done", done, 0);
    chk("z_err_hold", cpu_hold, 1);

    // Checksum mismatch
    w0 = wr_n;
    do_start(16'h0100, 16'd1, 1'b0);
    chk("m_err_clr", error, 0);
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    chk("m_wr_count", wr_n - w0, 1);
    chk("m_d0", wr_data[w0], 16'h0001);
    chk("m_error", error, 1);
    chk("m_done", done, 0);
    chk("m_hold", cpu_hold, 1);
    chk("m_busy", busy, 0);

    // Backpressure and address wrap
    w0 = wr_n;
    wr_ready_bad = 0;
    do_start(16'hFFFF, 16'd2, 1'b0);
    send_byte(8'h11, 1); send_byte(8'h11, 1);
    send_byte(8'h22, 1); send_byte(8'h22, 1);
    send_byte(8'h33, 1); send_byte(8'h33, 1);
    chk("w_wr_count", wr_n - w0, 2);
    chk("w_a0", wr_addr[w0], 16'hFFFE);
    chk("w_d0", wr_data[w0], 16'h1111);
    chk("w_a1", wr_addr[w0+1], 16'h0000);
    chk("w_d1", wr_data[w0+1], 16'h2222);
    chk("w_ready_in_write", wr_ready_bad, 0);
    chk("w_done", done, 1);

    // Mid-session reset after 3 bytes of a 4-word load
    w0 = wr_n;
    do_start(16'h0200, 16'd4, 1'b0);
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("r_busy", busy, 0);
    chk("r_hold", cpu_hold, 1);
    chk("r_ready", in_ready, 0);
    chk("r_addr", im_addr, 0);
    chk("r_data", im_data, 0);
    chk("r_done", done, 0);
    chk("r_wr_count", wr_n - w0, 1);
    chk("r_a0", wr_addr[w0], 16'h0200);
    chk("r_d0", wr_data[w0], 16'h0102);
    @(negedge clk);
    rst_n = 1'b1;

    // Start during a session is ignored
    w0 = wr_n;
    do_start(16'h0300, 16'd1, 1'b0);
    send_byte(8'h5A, 0);
    do_start(16'h0800, 16'd5, 1'b0);
    chk("b_busy", busy, 1);
    send_byte(8'hA5, 0);
    send_byte(8'h5A, 0); send_byte(8'hA5, 0);
    chk("b_wr_count", wr_n - w0, 1);
    chk("b_a0", wr_addr[w0], 16'h0300);
    chk("b_d0", wr_data[w0], 16'h5AA5);
    chk("b_done", done, 1);
    chk("b_hold", cpu_hold, 0);
    chk("en_eq_wr", wr_en_bad, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
